// File: rtl/motion_search_if.sv
// Bus bundle for the motion search engine: control handshake, result
// outputs and the two synchronous read ports (reference and search memory).
interface motion_search_if #(
  parameter int BLK    = 16,
  parameter int RANGE  = 8,
  parameter int PIX_W  = 8,
  parameter int DIST_W = 16
) ();
  localparam int NPE   = 2 * RANGE;
  localparam int SW    = BLK + 2 * RANGE;
  localparam int VEC_W = $clog2(2 * RANGE) + 1;
  localparam int AR_W  = $clog2(BLK * BLK);
  localparam int AS_W  = $clog2(SW * SW);
  localparam int RD_W  = $clog2(2 * RANGE) + 1;

  logic                    start;
  logic                    early_en;
  logic [DIST_W-1:0]       thresh;
  logic [AR_W-1:0]         addr_r;
  logic [PIX_W-1:0]        rdata_r;
  logic [AS_W-1:0]         addr_s;
  logic [NPE*PIX_W-1:0]    rdata_s;
  logic                    busy;
  logic                    done;
  logic [DIST_W-1:0]       best_dist;
  logic signed [VEC_W-1:0] mv_x;
  logic signed [VEC_W-1:0] mv_y;
  logic [RD_W-1:0]         rows_done;

  // Requester side: issues start, serves both memories, reads results.
  modport master (
    output start, early_en, thresh, rdata_r, rdata_s,
    input  addr_r, addr_s, busy, done, best_dist, mv_x, mv_y, rows_done
  );

  // Engine side.
  modport slave (
    input  start, early_en, thresh, rdata_r, rdata_s,
    output addr_r, addr_s, busy, done, best_dist, mv_x, mv_y, rows_done
  );
endinterface

// File: rtl/motion_search_engine.sv
// Full-search block-matching motion estimator. One dy row at a time, the
// BLK x BLK reference block is streamed against NPE horizontally shifted
// candidates in parallel; each PE accumulates a saturating SAD, and the
// candidates are then compared serially against the running best.
module motion_search_engine #(
  parameter int BLK    = 16,
  parameter int RANGE  = 8,
  parameter int PIX_W  = 8,
  parameter int DIST_W = 16
) (
  input  logic           clock,
  input  logic           reset,
  motion_search_if.slave bus
);
  localparam int NPE   = 2 * RANGE;
  localparam int SW    = BLK + 2 * RANGE;
  localparam int VEC_W = $clog2(2 * RANGE) + 1;
  localparam int AR_W  = $clog2(BLK * BLK);
  localparam int AS_W  = $clog2(SW * SW);
  localparam int CC_W  = $clog2(NPE);
  localparam int DY_W  = $clog2(2 * RANGE);
  localparam int RD_W  = $clog2(2 * RANGE) + 1;

  localparam logic [AR_W-1:0] LAST_FETCH = AR_W'(BLK * BLK - 1);
  localparam logic [CC_W-1:0] LAST_PE    = CC_W'(NPE - 1);
  localparam logic [DY_W-1:0] LAST_ROW   = DY_W'(2 * RANGE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [AR_W-1:0]         fcnt_q, fcnt_d;      // fetch cycle n within a row
  logic [CC_W-1:0]         ccnt_q, ccnt_d;      // PE index under comparison
  logic [DY_W-1:0]         dy_q, dy_d;          // current row dy_idx
  logic                    early_q, early_d;
  logic [DIST_W-1:0]       thresh_q, thresh_d;
  logic                    valid_q, valid_d;    // read data valid this cycle
  logic                    first_q, first_d;    // first valid data of a row
  logic [DIST_W-1:0]       acc_q [NPE];
  logic [DIST_W-1:0]       acc_d [NPE];
  logic [DIST_W-1:0]       best_q, best_d;
  logic signed [VEC_W-1:0] mvx_q, mvx_d;
  logic signed [VEC_W-1:0] mvy_q, mvy_d;
  logic [RD_W-1:0]         rows_q, rows_d;
  logic [DIST_W-1:0]       sad_sel;
  logic [31:0]             row_i, col_j;

  // Saturating SAD step for one PE: load on the row's first datum, else add.
  function automatic logic [DIST_W-1:0] acc_next(
    input logic [DIST_W-1:0] acc,
    input logic [PIX_W-1:0]  a,
    input logic [PIX_W-1:0]  b,
    input logic              first
  );
    logic [PIX_W-1:0]  diff;
    logic [DIST_W:0]   sum;
    diff = (a > b) ? (a - b) : (b - a);
    sum  = {1'b0, acc} + (DIST_W + 1)'(diff);
    if (first)          acc_next = DIST_W'(diff);
    else if (sum[DIST_W]) acc_next = '1;
    else                acc_next = sum[DIST_W-1:0];
  endfunction

  // Next-state and result-update logic of the search sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    ccnt_d   = ccnt_q;
    dy_d     = dy_q;
    early_d  = early_q;
    thresh_d = thresh_q;
    best_d   = best_q;
    mvx_d    = mvx_q;
    mvy_d    = mvy_q;
    rows_d   = rows_q;
    valid_d  = (state_q == S_FETCH);
    first_d  = (state_q == S_FETCH) && (fcnt_q == '0);
    sad_sel  = acc_q[ccnt_q];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          early_d  = bus.early_en;
          thresh_d = bus.thresh;
          rows_d   = '0;
          dy_d     = '0;
          fcnt_d   = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fcnt_q == LAST_FETCH) begin
          fcnt_d  = '0;
          state_d = S_DRAIN;
        end else begin
          fcnt_d = fcnt_q + AR_W'(1);
        end
      end
      S_DRAIN: begin
        ccnt_d  = '0;
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        // The very first candidate of a search seeds the best unconditionally;
        // strict < afterwards makes the earliest (smallest dy, then dx) win ties.
        if (((dy_q == '0) && (ccnt_q == '0)) || (sad_sel < best_q)) begin
          best_d = sad_sel;
          mvx_d  = VEC_W'(ccnt_q) - VEC_W'(RANGE);
          mvy_d  = VEC_W'(dy_q) - VEC_W'(RANGE);
        end
        if (ccnt_q == LAST_PE) begin
          ccnt_d = '0;
          rows_d = rows_q + RD_W'(1);
          // Early exit looks at the best including this row's last candidate.
          if ((dy_q == LAST_ROW) || (early_q && (best_d <= thresh_q))) begin
            state_d = S_DONE;
          end else begin
            dy_d    = dy_q + DY_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          ccnt_d = ccnt_q + CC_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-PE accumulator update from the reference pixel and its search lane.
  always_comb begin
    for (int k = 0; k < NPE; k++) begin
      acc_d[k] = acc_q[k];
      if (valid_q) begin
        acc_d[k] = acc_next(acc_q[k], bus.rdata_r, bus.rdata_s[k*PIX_W +: PIX_W], first_q);
      end
    end
  end

  // Read addresses: reference walks i*BLK+j, search walks the same (i, j)
  // offset down by dy_idx rows; both park at 0 whenever the engine is idle.
  always_comb begin
    row_i      = 32'(fcnt_q) / 32'(BLK);
    col_j      = 32'(fcnt_q) % 32'(BLK);
    bus.addr_r = '0;
    bus.addr_s = '0;
    if (state_q == S_FETCH) begin
      bus.addr_r = fcnt_q;
      bus.addr_s = AS_W'((32'(dy_q) + row_i) * 32'(SW) + col_j);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!reset) begin
      state_q  <= S_IDLE;
      fcnt_q   <= '0;
      ccnt_q   <= '0;
      dy_q     <= '0;
      early_q  <= 1'b0;
      thresh_q <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      best_q   <= '1;
      mvx_q    <= '0;
      mvy_q    <= '0;
      rows_q   <= '0;
      // NOTE: the small PE accumulator array is reset explicitly because an aborted search must leave no partial sums behind.
      for (int k = 0; k < NPE; k++) acc_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      ccnt_q   <= ccnt_d;
      dy_q     <= dy_d;
      early_q  <= early_d;
      thresh_q <= thresh_d;
      valid_q  <= valid_d;
      first_q  <= first_d;
      best_q   <= best_d;
      mvx_q    <= mvx_d;
      mvy_q    <= mvy_d;
      rows_q   <= rows_d;
      for (int k = 0; k < NPE; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.best_dist = best_q;
  assign bus.mv_x      = mvx_q;
  assign bus.mv_y      = mvy_q;
  assign bus.rows_done = rows_q;
endmodule

// File: tb/tb_motion_search_engine.sv
// Self-checking bench for motion_search_engine: directed boundary scenarios
// plus randomized searches checked against a plain full-search model.
module tb_motion_search_engine;
  localparam int BLK      = 16;
  localparam int SW       = 32;
  localparam int NPE      = 16;
  localparam int ROW_LAT  = BLK * BLK + 1 + NPE;
  localparam int FULL_LAT = 1 + 16 * ROW_LAT;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ref_px [BLK*BLK];
  int   srch   [SW*SW];

  always #5 clock = ~clock;

  motion_search_if                bus ();
  motion_search_if #(.DIST_W(12)) bus12 ();

  motion_search_engine dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  motion_search_engine #(.DIST_W(12)) dut12 (
    .clock(clock),
    .reset(reset),
    .bus  (bus12)
  );

  function automatic logic [NPE*8-1:0] lanes(input int a);
    logic [NPE*8-1:0] v;
    for (int k = 0; k < NPE; k++) v[k*8 +: 8] = 8'(srch[(a + k) % (SW*SW)]);
    return v;
  endfunction

  // Synchronous-read memories shared by both engines.
  always @(posedge clock) begin
    bus.rdata_r   <= 8'(ref_px[bus.addr_r]);
    bus.rdata_s   <= lanes(int'(bus.addr_s));
    bus12.rdata_r <= 8'(ref_px[bus12.addr_r]);
    bus12.rdata_s <= lanes(int'(bus12.addr_s));
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  // Full search with the same rules, computed directly from pixel arrays.
  function automatic void model(input bit ee, input int th, input int maxv,
                                output int best, output int mx, output int my, output int rows);
    best = 0; mx = 0; my = 0; rows = 0;
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 16; k++) begin
        int s;
        s = 0;
        for (int i = 0; i < BLK; i++)
          for (int j = 0; j < BLK; j++) begin
            int d;
            d = ref_px[i*BLK + j] - srch[(r + i)*SW + k + j];
            s += (d < 0) ? -d : d;
          end
        if (s > maxv) s = maxv;
        if ((r == 0 && k == 0) || s < best) begin
          best = s; mx = k - 8; my = r - 8;
        end
      end
      rows = r + 1;
      if (ee && best <= th) break;
    end
  endfunction

  task automatic fill(input int rlo, input int rhi, input int slo, input int shi);
    for (int i = 0; i < BLK*BLK; i++) ref_px[i] = $urandom_range(rhi, rlo);
    for (int i = 0; i < SW*SW; i++)   srch[i]   = $urandom_range(shi, slo);
  endtask

  task automatic place(input int dx, input int dy);
    for (int i = 0; i < BLK; i++)
      for (int j = 0; j < BLK; j++)
        srch[(dy + 8 + i)*SW + dx + 8 + j] = ref_px[i*BLK + j];
  endtask

  task automatic drive_start(input bit sel, input bit s, input bit ee, input int th);
    if (sel) begin
      bus12.start = s; bus12.early_en = ee; bus12.thresh = 12'(th);
    end else begin
      bus.start = s; bus.early_en = ee; bus.thresh = 16'(th);
    end
  endtask

  task automatic get_result(input bit sel, output int b, output int mx, output int my,
                            output int rows, output int busy);
    if (sel) begin
      b = int'(bus12.best_dist); mx = int'(bus12.mv_x); my = int'(bus12.mv_y);
      rows = int'(bus12.rows_done); busy = int'(bus12.busy);
    end else begin
      b = int'(bus.best_dist); mx = int'(bus.mv_x); my = int'(bus.mv_y);
      rows = int'(bus.rows_done); busy = int'(bus.busy);
    end
  endtask

  // Pulse start, then count negedges until done; lat is that count.
  task automatic launch(input bit sel, input bit ee, input int th, input int repulse_at,
                        input bit chk_addr, input int tail, output int lat, output int pulses);
    int cnt;
    @(negedge clock);
    drive_start(sel, 1'b1, ee, th);
    @(negedge clock);
    drive_start(sel, 1'b0, ee, th);
    cnt = 1; lat = -1; pulses = 0;
    while (lat < 0 && cnt <= FULL_LAT + 100) begin
      if (chk_addr && cnt <= 40) begin
        checks++;
        if (bus.addr_r !== 8'(cnt - 1) ||
            bus.addr_s !== 10'(((cnt - 1) / 16) * SW + (cnt - 1) % 16) || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL fetch_addr n=%0d: addr_r=%0d addr_s=%0d busy=%0b, required %0d %0d 1",
                   cnt - 1, bus.addr_r, bus.addr_s, bus.busy, cnt - 1,
                   ((cnt - 1) / 16) * SW + (cnt - 1) % 16);
        end
      end
      if (cnt == repulse_at) drive_start(sel, 1'b1, ee, th);
      else if (cnt == repulse_at + 1) drive_start(sel, 1'b0, ee, th);
      if ((sel ? bus12.done : bus.done) === 1'b1) begin
        lat = cnt; pulses++;
      end else begin
        @(negedge clock); cnt++;
      end
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, required done", FULL_LAT + 100);
    end
    repeat (tail) begin
      @(negedge clock);
      if ((sel ? bus12.done : bus.done) === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    int obs [9];
    int exp [9];
    reset = 1'b0;
    repeat (3) @(negedge clock);
    obs = '{int'(bus.busy), int'(bus.done), int'(bus.best_dist), int'(bus.mv_x), int'(bus.mv_y),
            int'(bus.rows_done), int'(bus.addr_r), int'(bus.addr_s), int'(bus12.best_dist)};
    exp = '{0, 0, 65535, 0, 0, 0, 0, 0, 4095};
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs[i] !== exp[i]) begin
        errors++;
        $display("FAIL reset_value[%0d]: got %0d, required %0d", i, obs[i], exp[i]);
      end
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Check a finished search against expected values, inline per field.
  task automatic test_exact_match();
    int lat, pul, b, mx, my, rows, busy;
    fill(1, 255, 0, 255);
    place(3, -2);
    launch(1'b0, 1'b0, 0, -1, 1'b1, 3, lat, pul);
    get_result(1'b0, b, mx, my, rows, busy);
    checks += 5;
    if (lat !== FULL_LAT) begin errors++; $display("FAIL exact_lat: got %0d, required %0d", lat, FULL_LAT); end
    if (pul !== 1) begin errors++; $display("FAIL exact_pulses: got %0d, required 1", pul); end
    if (b !== 0) begin errors++; $display("FAIL exact_best: got %0d, required 0", b); end
    if (mx !== 3 || my !== -2) begin errors++; $display("FAIL exact_mv: got (%0d,%0d), required (3,-2)", mx, my); end
    if (rows !== 16 || busy !== 0) begin errors++; $display("FAIL exact_rows_busy: got %0d/%0d, required 16/0", rows, busy); end
  endtask

  task automatic test_all_zero();
    int lat, pul, b, mx, my, rows, busy;
    fill(0, 0, 0, 0);
    launch(1'b0, 1'b0, 0, -1, 1'b0, 0, lat, pul);
    repeat (5) @(negedge clock);
    get_result(1'b0, b, mx, my, rows, busy);
    checks += 3;
    if (lat !== FULL_LAT) begin errors++; $display("FAIL zero_lat: got %0d, required %0d", lat, FULL_LAT); end
    if (b !== 0 || rows !== 16) begin errors++; $display("FAIL zero_hold_best_rows: got %0d/%0d, required 0/16", b, rows); end
    if (mx !== -8 || my !== -8) begin errors++; $display("FAIL zero_tiebreak_mv: got (%0d,%0d), required (-8,-8)", mx, my); end
  endtask

  task automatic test_saturation();
    int lat, pul, b, mx, my, rows, busy;
    fill(255, 255, 0, 0);
    launch(1'b1, 1'b0, 0, -1, 1'b0, 2, lat, pul);
    get_result(1'b1, b, mx, my, rows, busy);
    checks += 3;
    if (lat !== FULL_LAT || pul !== 1) begin errors++; $display("FAIL sat_lat_pulses: got %0d/%0d, required %0d/1", lat, pul, FULL_LAT); end
    if (b !== 4095) begin errors++; $display("FAIL sat_best: got %0d, required 4095", b); end
    if (mx !== -8 || my !== -8 || rows !== 16) begin errors++; $display("FAIL sat_mv_rows: got (%0d,%0d) %0d, required (-8,-8) 16", mx, my, rows); end
  endtask

  task automatic test_early_term();
    int lat, pul, b, mx, my, rows, busy;
    fill(1, 255, 0, 255);
    place(-5, -8);
    launch(1'b0, 1'b1, 0, -1, 1'b0, 2, lat, pul);
    get_result(1'b0, b, mx, my, rows, busy);
    checks += 3;
    if (lat !== 1 + ROW_LAT) begin errors++; $display("FAIL early_lat: got %0d, required %0d", lat, 1 + ROW_LAT); end
    if (rows !== 1 || b !== 0) begin errors++; $display("FAIL early_rows_best: got %0d/%0d, required 1/0", rows, b); end
    if (mx !== -5 || my !== -8) begin errors++; $display("FAIL early_mv: got (%0d,%0d), required (-5,-8)", mx, my); end
  endtask

  task automatic test_reset_abort();
    int lat, pul, b, mx, my, rows, busy, stray;
    fill(1, 255, 0, 255);
    place(3, -2);
    @(negedge clock); drive_start(1'b0, 1'b1, 1'b0, 0);
    @(negedge clock); drive_start(1'b0, 1'b0, 1'b0, 0);
    repeat (999) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    get_result(1'b0, b, mx, my, rows, busy);
    checks += 2;
    if (busy !== 0 || b !== 65535) begin errors++; $display("FAIL abort_state: busy=%0d best=%0d, required 0 65535", busy, b); end
    if (mx !== 0 || my !== 0 || rows !== 0 || bus.addr_s !== 10'd0) begin
      errors++; $display("FAIL abort_clear: mv=(%0d,%0d) rows=%0d addr_s=%0d, required 0", mx, my, rows, bus.addr_s);
    end
    reset = 1'b1;
    stray = 0;
    repeat (20) begin @(negedge clock); if (bus.done === 1'b1) stray++; end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL abort_done: got %0d pulses, required 0", stray); end
    launch(1'b0, 1'b0, 0, -1, 1'b0, 2, lat, pul);
    get_result(1'b0, b, mx, my, rows, busy);
    checks += 2;
    if (lat !== FULL_LAT || pul !== 1) begin errors++; $display("FAIL abort_restart_lat: got %0d/%0d, required %0d/1", lat, pul, FULL_LAT); end
    if (b !== 0 || mx !== 3 || my !== -2) begin errors++; $display("FAIL abort_restart_result: got %0d (%0d,%0d), required 0 (3,-2)", b, mx, my); end
  endtask

  task automatic test_busy_start();
    int lat, pul, b, mx, my, rows, busy;
    fill(1, 255, 0, 255);
    place(3, -2);
    launch(1'b0, 1'b0, 0, 500, 1'b0, 5, lat, pul);
    get_result(1'b0, b, mx, my, rows, busy);
    checks += 2;
    if (lat !== FULL_LAT || pul !== 1) begin errors++; $display("FAIL busy_start_lat: got %0d/%0d, required %0d/1", lat, pul, FULL_LAT); end
    if (b !== 0 || mx !== 3 || my !== -2 || rows !== 16) begin
      errors++; $display("FAIL busy_start_result: got %0d (%0d,%0d) %0d, required 0 (3,-2) 16", b, mx, my, rows);
    end
  endtask

  // Random pixels and random early-exit settings against the model.
  task automatic test_random(input int iters, input bit b2b);
    int lat, pul, b, mx, my, rows, busy, eb, emx, emy, erows, th;
    bit ee;
    for (int it = 0; it < iters; it++) begin
      fill(0, 255, 0, 255);
      if (b2b) place((it == 0) ? -8 : 7, (it == 0) ? 7 : -8);
      ee = b2b ? 1'b0 : 1'($urandom_range(1, 0));
      th = $urandom_range(22000, 18000);
      model(ee, th, 65535, eb, emx, emy, erows);
      launch(1'b0, ee, th, -1, 1'b0, b2b ? 0 : 2, lat, pul);
      get_result(1'b0, b, mx, my, rows, busy);
      checks += 3;
      if (lat !== 1 + erows * ROW_LAT) begin errors++; $display("FAIL rand_lat[%0d]: got %0d, required %0d", it, lat, 1 + erows * ROW_LAT); end
      if (b !== eb || rows !== erows) begin errors++; $display("FAIL rand_best_rows[%0d]: got %0d/%0d, required %0d/%0d", it, b, rows, eb, erows); end
      if (mx !== emx || my !== emy) begin errors++; $display("FAIL rand_mv[%0d]: got (%0d,%0d), required (%0d,%0d)", it, mx, my, emx, emy); end
    end
  endtask

  initial begin
    drive_start(1'b0, 1'b0, 1'b0, 0);
    drive_start(1'b1, 1'b0, 1'b0, 0);
    test_reset();
    test_exact_match();
    test_all_zero();
    test_saturation();
    test_early_term();
    test_reset_abort();
    test_busy_start();
    test_random(3, 1'b0);
    test_random(2, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/motion_search_engine.md
MOTION_SEARCH_ENGINE -- requirements
Module: motion_search_engine

Interface
REQ-001 Parameter BLK, default 16: block edge in pixels; reference block is BLK x BLK.
REQ-002 Parameter RANGE, default 8: displacement dx, dy each span -RANGE..RANGE-1.
REQ-003 Parameter PIX_W, default 8: unsigned pixel width.
REQ-004 Parameter DIST_W, default 16: SAD accumulator and best_dist width.
REQ-005 Derived values: NPE = 2*RANGE PEs; SW = BLK+2*RANGE search-row stride; VEC_W = clog2(2*RANGE)+1.
REQ-006 clock  in  1  single clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 start  in  1  one-cycle request, honoured only in IDLE.
REQ-009 early_en  in  1  enables early termination; sampled with start.
REQ-010 thresh  in  DIST_W  early-termination threshold; sampled with start.
REQ-011 addr_r  out  clog2(BLK*BLK)  reference read address, i*BLK+j.
REQ-012 rdata_r  in  PIX_W  reference pixel; valid one cycle after addr_r.
REQ-013 addr_s  out  clog2(SW*SW)  search read address, row*SW+col.
REQ-014 rdata_s  in  NPE*PIX_W  pixels at columns col..col+NPE-1; lane k at bits [k*PIX_W +: PIX_W]; valid one cycle after addr_s.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse at search completion.
REQ-017 best_dist  out  DIST_W  minimum SAD found.
REQ-018 mv_x, mv_y  out  VEC_W each  signed two's-complement vector of the best candidate.
REQ-019 rows_done  out  clog2(2*RANGE)+1  number of dy rows fully evaluated.

Function
REQ-020 FSM states: IDLE, FETCH, DRAIN, COMPARE, DONE; the only transitions are those in REQ-021 to REQ-025.
REQ-021 IDLE -> FETCH on start=1; on that edge the block latches early_en and thresh, clears rows_done, and sets dy_idx=0.
REQ-022 FETCH runs exactly BLK*BLK cycles for each row dy_idx; in cycle n, i=n/BLK, j=n%BLK, addr_r=i*BLK+j, addr_s=(dy_idx+i)*SW+j.
REQ-023 After the last FETCH cycle the FSM spends exactly one DRAIN cycle to absorb the final read data, then enters COMPARE.
REQ-024 COMPARE lasts NPE cycles; in cycle k, PE k's SAD is compared against best_dist.
REQ-025 After COMPARE, rows_done increments; the FSM goes to DONE if dy_idx=2*RANGE-1, or if early_en=1 and best_dist<=thresh; otherwise it increments dy_idx and returns to FETCH.
REQ-026 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-027 Each PE k adds |rdata_r - lane k| on every valid data cycle, using a full-width unsigned absolute difference.
REQ-028 On the first valid data cycle of each row, each accumulator loads the difference instead of adding it.
REQ-029 Accumulation saturates: any sum exceeding 2^DIST_W-1 clamps to 2^DIST_W-1 and holds there for the rest of the row.
REQ-030 Candidate mapping: dx = k-RANGE, dy = dy_idx-RANGE.
REQ-031 Compare rule: the first candidate of a search (dy_idx=0, k=0) always loads best_dist, mv_x and mv_y; every later candidate loads only if its SAD < best_dist (strict).
REQ-032 Tie-break consequence of REQ-031: among equal SADs, the smallest dy wins, then the smallest dx.
REQ-033 Total latency: done is high exactly 1 + R*(BLK*BLK+1+NPE) cycles after the start edge, where R is the number of rows evaluated; with defaults and a full search this is 4369 cycles.
REQ-034 start asserted while busy=1 is ignored; it has no effect on state or outputs.
REQ-035 best_dist, mv_x, mv_y and rows_done update only during COMPARE and the REQ-025 transition, and hold through DONE and IDLE until the next accepted start.
REQ-036 When busy=0, addr_r and addr_s are 0.

Reset
REQ-037 When reset=0 at a clock edge, the FSM goes to IDLE and busy=0, done=0, best_dist=all-ones, mv_x=0, mv_y=0, rows_done=0, addresses=0, accumulators=0.
REQ-038 Reset asserted mid-search aborts the search: no done pulse is generated and no partial result is retained.

Verification
REQ-039 Defaults; R random 1..255; S exact copy of R placed at dx=+3, dy=-2; all other positions mismatched -> best_dist=0, mv_x=3, mv_y=-2, rows_done=16, done pulse 4369 cycles after start.
REQ-040 All pixels of R and S = 0 -> best_dist=0, mv_x=-8, mv_y=-8 (tie-break).
REQ-041 DIST_W=12, R=255 everywhere, S=0 everywhere -> every SAD=4095 (saturated), best_dist=4095, mv=(-8,-8).
REQ-042 early_en=1, thresh=0, exact match at dy=-8, dx=-5 -> done 274 cycles after start, rows_done=1, best_dist=0, mv=(-5,-8).
REQ-043 reset=0 for 1 cycle at cycle 1000 of a search -> next cycle busy=0, best_dist=all-ones, no done pulse; a new start then completes in 4369 cycles.
REQ-044 start re-pulsed at cycle 500 of a search -> ignored; single done pulse at cycle 4369 with unchanged result.
